// File: rtl/asym_flush_fifo.sv
// Narrow-write / wide-read FIFO. A flush drains every slot stored up to the capture cycle
// as zero-padded words while writes keep flowing in behind it.
module asym_flush_fifo #(
    parameter int WR_W     = 4,
    parameter int RD_W     = 32,
    parameter int CAP_BITS = 128,
    localparam int RATIO   = RD_W / WR_W,
    localparam int NSLOT   = CAP_BITS / WR_W,
    localparam int PW      = $clog2(NSLOT) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_vld,
    input  logic [WR_W-1:0] wr_data,
    output logic            wr_rdy,
    input  logic            rd,
    output logic [RD_W-1:0] rd_data,
    output logic            data_avail,
    input  logic            flush_req,
    output logic            flush_vld,
    output logic            flush_done,
    output logic            full,
    output logic            empty,
    output logic [PW-1:0]   level,
    output logic            err
);
    // state | meaning
    // IDLE  | normal reads allowed, flush_req captures the drain target
    // DRAIN | one padded beat per cycle until the target is reached
    // HOLD  | flush finished, waiting for flush_req to drop
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_HOLD} state_t;

    localparam int AW = PW - 1;

    state_t          state, state_nxt;
    logic [WR_W-1:0] mem [NSLOT];
    logic [PW-1:0]   wr_ptr, rd_ptr, tgt, rem, n_adv;
    logic [RD_W-1:0] word_raw;
    logic            wr_acc;

    assign level  = wr_ptr - rd_ptr;
    assign full   = (level == PW'(NSLOT));
    assign empty  = (level == '0);
    assign wr_rdy = !full;
    assign wr_acc = wr_vld && !full;
    assign rem    = tgt - rd_ptr;

    // Slot index wraps naturally because NSLOT is a power of two.
    always_comb begin
        word_raw = '0;
        for (int i = 0; i < RATIO; i++)
            word_raw[i*WR_W +: WR_W] = mem[rd_ptr[AW-1:0] + AW'(i)];
    end

    always_comb begin
        state_nxt  = state;
        flush_vld  = 1'b0;
        flush_done = 1'b0;
        data_avail = 1'b0;
        n_adv      = '0;
        rd_data    = '0;
        case (state)
            S_IDLE: begin
                data_avail = (level >= PW'(RATIO));
                if (rd && data_avail)
                    n_adv = PW'(RATIO);
                if (flush_req)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                n_adv     = (rem > PW'(RATIO)) ? PW'(RATIO) : rem;
                flush_vld = (rem != '0);
                if (rem <= PW'(RATIO)) begin
                    flush_done = 1'b1;
                    state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!flush_req)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Slots beyond the advance count read as zero padding.
        for (int i = 0; i < RATIO; i++)
            if (PW'(i) < n_adv)
                rd_data[i*WR_W +: WR_W] = word_raw[i*WR_W +: WR_W];
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tgt    <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + PW'(wr_acc);
            rd_ptr <= rd_ptr + n_adv;
            if (state == S_IDLE && flush_req)
                tgt <= wr_ptr + PW'(wr_acc);
            err    <= err | (wr_vld && full) | (rd && !data_avail);
        end
    end
endmodule

// File: tb/tb_asym_flush_fifo.sv
// Scoreboard bench for asym_flush_fifo: a slot queue tracks stored data; reads and
// flush beats pop from it and compare.
module tb_asym_flush_fifo;
    localparam int WR_W  = 4;
    localparam int RD_W  = 32;
    localparam int NSLOT = 32;
    localparam int RATIO = 8;
    localparam int PW    = 6;

    logic            clk = 1'b0;
    logic            rst, wr_vld, rd, flush_req;
    logic [WR_W-1:0] wr_data;
    logic            wr_rdy, data_avail, flush_vld, flush_done, full, empty, err;
    logic [RD_W-1:0] rd_data;
    logic [PW-1:0]   level;

    int              n_chk = 0;
    int              n_err = 0;
    logic [WR_W-1:0] q[$];
    logic [WR_W-1:0] wctr = 4'h0;

    asym_flush_fifo #(.WR_W(WR_W), .RD_W(RD_W), .CAP_BITS(128)) dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd(rd), .rd_data(rd_data), .data_avail(data_avail), .flush_req(flush_req),
        .flush_vld(flush_vld), .flush_done(flush_done), .full(full), .empty(empty),
        .level(level), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_vld = 1'b0; rd = 1'b0; flush_req = 1'b0; wr_data = '0;
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic wr_slot(input logic [WR_W-1:0] d);
        wr_vld = 1'b1; wr_data = d;
        @(negedge clk);
        chk("wr_rdy", {31'd0, wr_rdy}, {31'd0, q.size() < NSLOT});
        if (q.size() < NSLOT) q.push_back(d);
        tick();
        wr_vld = 1'b0;
    endtask

    task automatic rd_word();
        logic [RD_W-1:0] e;
        e = '0;
        rd = 1'b1;
        @(negedge clk);
        chk("data_avail", {31'd0, data_avail}, 32'd1);
        for (int i = 0; i < RATIO; i++)
            if (q.size() > 0) e[i*WR_W +: WR_W] = q.pop_front();
        chk("rd_data", rd_data, e);
        tick();
        rd = 1'b0;
    endtask

    task automatic do_flush(input bit cap_wr, input logic [WR_W-1:0] cap_d,
                            input bit drain_wr, input int exp_beats);
        int rem, n, beats;
        bit done, acc;
        logic [RD_W-1:0] e;
        beats = 0; done = 1'b0;
        flush_req = 1'b1; wr_vld = cap_wr; wr_data = cap_d;
        @(negedge clk);
        if (cap_wr && q.size() < NSLOT) q.push_back(cap_d);
        rem = q.size();
        chk("flush_vld_cap", {31'd0, flush_vld}, 32'd0);
        tick();
        wr_vld = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            if (drain_wr) begin wr_vld = 1'b1; wr_data = wctr; end
            @(negedge clk);
            acc = (q.size() < NSLOT);
            chk("flush_vld", {31'd0, flush_vld}, {31'd0, rem != 0});
            chk("avail_drain", {31'd0, data_avail}, 32'd0);
            n = (rem > RATIO) ? RATIO : rem;
            e = '0;
            for (int i = 0; i < n; i++) e[i*WR_W +: WR_W] = q.pop_front();
            if (rem != 0) begin
                chk("flush_data", rd_data, e);
                beats++;
            end
            done = (rem <= RATIO);
            chk("flush_done", {31'd0, flush_done}, {31'd0, done});
            rem -= n;
            if (drain_wr && acc) begin q.push_back(wctr); wctr++; end
            tick();
            wr_vld = 1'b0;
        end
        chk("flush_beats", beats, exp_beats);
        @(negedge clk);
        chk("hold_quiet", {30'd0, flush_vld, flush_done}, 32'd0);
        chk("hold_avail", {31'd0, data_avail}, 32'd0);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk("hold_release_avail", {31'd0, data_avail}, 32'd0);
        tick();
    endtask

    initial begin
        // 1: reset state and one word
        do_reset();
        @(negedge clk);
        chk("rst_flags", {25'd0, wr_rdy, empty, full, data_avail, flush_vld, flush_done, err},
            {25'd0, 7'b1100000});
        chk("rst_level", {26'd0, level}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        tick();
        for (int i = 1; i <= 8; i++) wr_slot(WR_W'(i));
        rd_word();
        @(negedge clk);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_err", {31'd0, err}, 32'd0);
        tick();

        // 2: fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < 32; i++) wr_slot(WR_W'(i * 7 + 3));
        @(negedge clk);
        chk("t2_full", {30'd0, full, wr_rdy}, 32'b10);
        chk("t2_err_pre", {31'd0, err}, 32'd0);
        tick();
        wr_slot(4'hF);
        @(negedge clk);
        chk("t2_err", {31'd0, err}, 32'd1);
        chk("t2_level", {26'd0, level}, 32'd32);
        tick();
        for (int i = 0; i < 4; i++) rd_word();
        @(negedge clk);
        chk("t2_empty", {31'd0, empty}, 32'd1);
        tick();

        // 3: short flush with capture-cycle write
        do_reset();
        wr_slot(4'hA); wr_slot(4'hB); wr_slot(4'hC);
        do_flush(1'b1, 4'hD, 1'b0, 1);
        chk("t3_empty", {31'd0, empty}, 32'd1);

        // 4: two-beat flush with writes continuing behind it
        do_reset();
        for (int i = 0; i < 11; i++) wr_slot(WR_W'(i + 1));
        wctr = 4'h9;
        do_flush(1'b0, 4'h0, 1'b1, 2);
        @(negedge clk);
        chk("t4_level", {26'd0, level}, q.size());
        tick();
        for (int i = 0; i < 6; i++) begin wr_slot(wctr); wctr++; end
        rd_word();
        chk("t4_err", {31'd0, err}, 32'd0);

        // 5: flush word straddling the array end
        do_reset();
        for (int i = 0; i < 4; i++) wr_slot(WR_W'(i));
        do_flush(1'b0, 4'h0, 1'b0, 1);
        for (int i = 0; i < 24; i++) wr_slot(WR_W'(i + 5));
        for (int i = 0; i < 3; i++) rd_word();
        for (int i = 0; i < 6; i++) wr_slot(WR_W'(15 - i));
        do_flush(1'b0, 4'h0, 1'b0, 1);

        // 6: reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 11; i++) wr_slot(WR_W'(i + 2));
        flush_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; flush_req = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t6_flags", {28'd0, empty, flush_vld, flush_done, err}, 32'b1000);
        chk("t6_level", {26'd0, level}, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) wr_slot(WR_W'(i + 6));
        rd_word();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
